// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: opcode bit positions, addressing
// modes, datapath select codes, ULA operation codes and step indices.
package ctrl_pkg;

  localparam int OP_NOP = 0;
  localparam int OP_STA = 1;
  localparam int OP_LDA = 2;
  localparam int OP_ADD = 3;
  localparam int OP_SUB = 4;
  localparam int OP_AND = 5;
  localparam int OP_OR  = 6;
  localparam int OP_NOT = 7;
  localparam int OP_J   = 8;
  localparam int OP_JN  = 9;
  localparam int OP_JZ  = 10;
  localparam int OP_IN  = 11;
  localparam int OP_OUT = 12;
  localparam int OP_SHR = 13;
  localparam int OP_SHL = 14;
  localparam int OP_HLT = 15;

  typedef enum logic [1:0] {
    MODE_SOP = 2'b00,
    MODE_DIR = 2'b01,
    MODE_IND = 2'b10,
    MODE_IM  = 2'b11
  } mode_e;

  localparam logic [1:0] RDM_AC  = 2'b00;
  localparam logic [1:0] RDM_IN  = 2'b01;
  localparam logic [1:0] RDM_MEM = 2'b10;

  localparam logic [2:0] ULA_ADD  = 3'b000;
  localparam logic [2:0] ULA_SUB  = 3'b001;
  localparam logic [2:0] ULA_AND  = 3'b010;
  localparam logic [2:0] ULA_OR   = 3'b011;
  localparam logic [2:0] ULA_NOT  = 3'b100;
  localparam logic [2:0] ULA_SHR  = 3'b101;
  localparam logic [2:0] ULA_SHL  = 3'b110;
  localparam logic [2:0] ULA_PASS = 3'b111;

  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;
  localparam int T5 = 5;
  localparam int T6 = 6;
  localparam int T7 = 7;
  localparam int T8 = 8;
  localparam int T9 = 9;

  // Non-ALU opcodes (including LDA) select the pass-through operation.
  function automatic logic [2:0] ula_code(input logic [15:0] op);
    logic [2:0] code;
    code = ULA_PASS;
    if (op[OP_ADD]) code = ULA_ADD;
    if (op[OP_SUB]) code = ULA_SUB;
    if (op[OP_AND]) code = ULA_AND;
    if (op[OP_OR])  code = ULA_OR;
    if (op[OP_NOT]) code = ULA_NOT;
    if (op[OP_SHR]) code = ULA_SHR;
    if (op[OP_SHL]) code = ULA_SHL;
    return code;
  endfunction

  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

endpackage

// File: rtl/step_counter.sv
// One-hot timing step register. hold freezes the step, restart returns to T0,
// advance shifts to the next step; T9 and any stray encoding fall back to T0.
module step_counter
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 advance_i,
  input  logic                 restart_i,
  input  logic                 hold_i,
  output logic [NUM_STEPS-1:0] step_o
);

  localparam logic [NUM_STEPS-1:0] STEP_T0 = NUM_STEPS'(1);

  logic [NUM_STEPS-1:0] step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (!hold_i) begin
      if (restart_i || (|step_q[NUM_STEPS-1:T9]) || (step_q == '0)) begin
        step_d = STEP_T0;
      end else if (advance_i) begin
        step_d = step_q << 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= STEP_T0;
    else        step_q <= step_d;
  end

  assign step_o = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Accumulator CPU control unit: decodes the one-hot step, opcode, mode and flags
// into datapath strobes, with memory wait handshake, HLT/resume and illegal detection.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 10,
  parameter int unsigned OP_W      = 3,
  parameter bit          MEM_WAIT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          op_sel,
  input  logic [1:0]           mode,
  input  logic                 flag_n,
  input  logic                 flag_z,
  input  logic                 mem_ready,
  input  logic                 resume,
  output logic                 mem_req,
  output logic                 write_ac,
  output logic                 write_pc,
  output logic                 write_n,
  output logic                 write_z,
  output logic                 write_rdm,
  output logic                 write_ri,
  output logic                 write_out,
  output logic                 write_rem,
  output logic                 write_mem,
  output logic                 select_rem,
  output logic                 increment_pc,
  output logic [1:0]           select_rdm,
  output logic [OP_W-1:0]      op_ula,
  output logic [NUM_STEPS-1:0] step,
  output logic                 halted,
  output logic                 illegal
);

  logic halted_q, halted_d;
  logic done, stall;
  logic active, mem_ok, one_hot, legal;
  logic is_sop, is_alu, is_st, is_jmp, taken, dir, ind, data_step, final_step;
  mode_e md;

  assign md      = mode_e'(mode);
  assign dir     = (md == MODE_DIR);
  assign ind     = (md == MODE_IND);
  assign active  = rst_n & ~halted_q;
  assign mem_ok  = MEM_WAIT ? mem_ready : 1'b1;
  assign one_hot = is_onehot(op_sel);
  assign is_sop  = op_sel[OP_NOP] | op_sel[OP_NOT] | op_sel[OP_SHR] | op_sel[OP_SHL] | op_sel[OP_HLT];
  assign is_alu  = op_sel[OP_LDA] | op_sel[OP_ADD] | op_sel[OP_SUB] | op_sel[OP_AND] | op_sel[OP_OR];
  assign is_st   = op_sel[OP_STA] | op_sel[OP_IN];
  assign is_jmp  = op_sel[OP_J] | op_sel[OP_JN] | op_sel[OP_JZ];
  assign taken   = op_sel[OP_J] | (op_sel[OP_JN] & flag_n) | (op_sel[OP_JZ] & flag_z);
  assign legal   = (md == MODE_SOP) ? is_sop :
                   (md == MODE_IM)  ? (is_alu | op_sel[OP_OUT]) : ~is_sop;

  // Operand data access and final write steps; IND runs two steps later than DIR.
  assign data_step  = (dir & step[T6]) | (ind & step[T8]);
  assign final_step = ((md == MODE_IM) & step[T5]) | (dir & step[T7]) | (ind & step[T9]);

  assign op_ula = OP_W'(ula_code(op_sel));
  assign halted = halted_q;

  always_comb begin
    mem_req      = 1'b0;
    write_ac     = 1'b0;
    write_pc     = 1'b0;
    write_n      = 1'b0;
    write_z      = 1'b0;
    write_rdm    = 1'b0;
    write_ri     = 1'b0;
    write_out    = 1'b0;
    write_rem    = 1'b0;
    write_mem    = 1'b0;
    select_rem   = 1'b0;
    increment_pc = 1'b0;
    select_rdm   = RDM_AC;
    illegal      = 1'b0;
    done         = 1'b0;
    stall        = 1'b0;
    halted_d     = halted_q & ~resume;
    if (active) begin
      if (step[T0]) begin
        write_rem  = 1'b1;
        select_rem = 1'b1;
      end else if (step[T1] || step[T4] || (ind && step[T6]) || (data_step && !is_st)) begin
        // Memory read: every strobe waits for the cycle the memory completes.
        mem_req      = 1'b1;
        select_rdm   = RDM_MEM;
        write_rdm    = mem_ok;
        increment_pc = mem_ok & (step[T1] | step[T4]);
        stall        = ~mem_ok;
      end else if (step[T2]) begin
        write_ri = 1'b1;
      end else if (step[T3]) begin
        done = 1'b1;
        if (!one_hot) begin
          illegal = 1'b1;
        end else if (!legal) begin
          illegal      = 1'b1;
          increment_pc = 1'b1;
        end else if (md == MODE_SOP) begin
          if (op_sel[OP_NOT] || op_sel[OP_SHR] || op_sel[OP_SHL]) begin
            {write_ac, write_n, write_z} = 3'b111;
          end
          halted_d = op_sel[OP_HLT];
        end else if (is_jmp && !taken) begin
          increment_pc = 1'b1;
        end else begin
          done       = 1'b0;
          write_rem  = 1'b1;
          select_rem = 1'b1;
        end
      end else if (data_step) begin
        write_rdm  = 1'b1;
        select_rdm = op_sel[OP_IN] ? RDM_IN : RDM_AC;
      end else if (final_step) begin
        done = 1'b1;
        if (is_st) begin
          mem_req   = 1'b1;
          write_mem = mem_ok;
          stall     = ~mem_ok;
        end else if (op_sel[OP_OUT]) begin
          write_out = 1'b1;
        end else begin
          {write_ac, write_n, write_z} = 3'b111;
        end
      end else if (is_jmp && ((dir && step[T5]) || (ind && step[T7]))) begin
        write_pc = 1'b1;
        done     = 1'b1;
      end else if ((dir || ind) && (step[T5] || (ind && step[T7]))) begin
        write_rem = 1'b1;
      end else begin
        done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end

  step_counter #(
    .NUM_STEPS (NUM_STEPS)
  ) u_step_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance_i (~done),
    .restart_i (done),
    .hold_i    (halted_q | stall),
    .step_o    (step)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and randomized bench for control_sequencer: each instruction is
// expanded into its expected micro-step list and replayed cycle by cycle.
module tb_control_sequencer;

  localparam int NOP = 0, STA = 1, LDA = 2, ADD = 3, SUB = 4, AND_ = 5, OR_ = 6, NOT_ = 7;
  localparam int J = 8, JN = 9, JZ = 10, IN_ = 11, OUT_ = 12, SHR = 13, SHL = 14, HLT = 15;
  localparam logic [1:0] M_SOP = 2'b00, M_DIR = 2'b01, M_IND = 2'b10, M_IM = 2'b11;

  localparam logic [10:0] B_AC  = 11'(1) << 10;
  localparam logic [10:0] B_PC  = 11'(1) << 9;
  localparam logic [10:0] B_N   = 11'(1) << 8;
  localparam logic [10:0] B_Z   = 11'(1) << 7;
  localparam logic [10:0] B_RDM = 11'(1) << 6;
  localparam logic [10:0] B_RI  = 11'(1) << 5;
  localparam logic [10:0] B_OUT = 11'(1) << 4;
  localparam logic [10:0] B_REM = 11'(1) << 3;
  localparam logic [10:0] B_MEM = 11'(1) << 2;
  localparam logic [10:0] B_INC = 11'(1) << 1;
  localparam logic [10:0] B_ILL = 11'(1);
  localparam logic [10:0] ACNZ  = B_AC | B_N | B_Z;

  typedef struct packed {
    logic [10:0] s;
    logic        mem;
    logic        sel_rem;
    logic [1:0]  sel_rdm;
    logic [2:0]  ula;
  } micro_t;

  logic        clk, rst_n;
  logic [15:0] op_sel;
  logic [1:0]  mode;
  logic        flag_n, flag_z, mem_ready, resume;
  logic        mem_req, write_ac, write_pc, write_n, write_z, write_rdm, write_ri;
  logic        write_out, write_rem, write_mem, select_rem, increment_pc;
  logic [1:0]  select_rdm;
  logic [2:0]  op_ula;
  logic [9:0]  step;
  logic        halted, illegal;

  micro_t prog[$];
  int     checks = 0;
  int     errors = 0;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .op_sel(op_sel), .mode(mode), .flag_n(flag_n), .flag_z(flag_z),
    .mem_ready(mem_ready), .resume(resume), .mem_req(mem_req), .write_ac(write_ac),
    .write_pc(write_pc), .write_n(write_n), .write_z(write_z), .write_rdm(write_rdm),
    .write_ri(write_ri), .write_out(write_out), .write_rem(write_rem), .write_mem(write_mem),
    .select_rem(select_rem), .increment_pc(increment_pc), .select_rdm(select_rdm),
    .op_ula(op_ula), .step(step), .halted(halted), .illegal(illegal)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] obs_s();
    return {write_ac, write_pc, write_n, write_z, write_rdm, write_ri,
            write_out, write_rem, write_mem, increment_pc, illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic micro_t mk(input logic [10:0] s, input logic mem, input logic srem,
                                input logic [1:0] srdm, input logic [2:0] ula);
    micro_t m;
    m.s = s; m.mem = mem; m.sel_rem = srem; m.sel_rdm = srdm; m.ula = ula;
    return m;
  endfunction

  function automatic logic [2:0] ula_of(input int op);
    case (op)
      ADD:  return 3'b000;
      SUB:  return 3'b001;
      AND_: return 3'b010;
      OR_:  return 3'b011;
      NOT_: return 3'b100;
      SHR:  return 3'b101;
      SHL:  return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  function automatic micro_t final_write(input int op);
    if (op == STA || op == IN_) return mk(B_MEM, 1'b1, 1'b0, 2'b00, 3'b0);
    if (op == OUT_)             return mk(B_OUT, 1'b0, 1'b0, 2'b00, 3'b0);
    return mk(ACNZ, 1'b0, 1'b0, 2'b00, ula_of(op));
  endfunction

  // Reference model: the instruction as a list of micro-steps, one per T-state.
  task automatic build(input logic [15:0] ops, input logic [1:0] md, input logic fn,
                       input logic fz, output bit halts);
    int op;
    bit sop, jmp, st, legal, tk;
    micro_t rem_pc, rd_inc, rd, rem_rdm;
    rem_pc  = mk(B_REM, 1'b0, 1'b1, 2'b00, 3'b0);
    rd_inc  = mk(B_RDM | B_INC, 1'b1, 1'b0, 2'b10, 3'b0);
    rd      = mk(B_RDM, 1'b1, 1'b0, 2'b10, 3'b0);
    rem_rdm = mk(B_REM, 1'b0, 1'b0, 2'b00, 3'b0);
    halts = 1'b0;
    prog.delete();
    prog.push_back(rem_pc);
    prog.push_back(rd_inc);
    prog.push_back(mk(B_RI, 1'b0, 1'b0, 2'b00, 3'b0));
    if ($countones(ops) != 1) begin
      prog.push_back(mk(B_ILL, 1'b0, 1'b0, 2'b00, 3'b0));
      return;
    end
    op = 0;
    for (int i = 0; i < 16; i++) if (ops[i]) op = i;
    sop = (op == NOP || op == NOT_ || op == SHR || op == SHL || op == HLT);
    jmp = (op == J || op == JN || op == JZ);
    st  = (op == STA || op == IN_);
    if (md == M_SOP)     legal = sop;
    else if (md == M_IM) legal = (op == LDA || op == ADD || op == SUB || op == AND_ || op == OR_ || op == OUT_);
    else                 legal = !sop;
    if (!legal) begin
      prog.push_back(mk(B_ILL | B_INC, 1'b0, 1'b0, 2'b00, 3'b0));
      return;
    end
    if (md == M_SOP) begin
      if (op == NOT_ || op == SHR || op == SHL) prog.push_back(mk(ACNZ, 1'b0, 1'b0, 2'b00, ula_of(op)));
      else prog.push_back(mk(11'd0, 1'b0, 1'b0, 2'b00, 3'b0));
      halts = (op == HLT);
      return;
    end
    tk = (op == J) || (op == JN && fn) || (op == JZ && fz);
    if (jmp && !tk) begin
      prog.push_back(mk(B_INC, 1'b0, 1'b0, 2'b00, 3'b0));
      return;
    end
    prog.push_back(rem_pc);
    prog.push_back(rd_inc);
    if (md == M_IM) begin
      prog.push_back(final_write(op));
      return;
    end
    if (jmp && md == M_DIR) begin
      prog.push_back(mk(B_PC, 1'b0, 1'b0, 2'b00, 3'b0));
      return;
    end
    prog.push_back(rem_rdm);
    if (md == M_IND) begin
      prog.push_back(rd);
      if (jmp) begin
        prog.push_back(mk(B_PC, 1'b0, 1'b0, 2'b00, 3'b0));
        return;
      end
      prog.push_back(rem_rdm);
    end
    if (op == STA)      prog.push_back(mk(B_RDM, 1'b0, 1'b0, 2'b00, 3'b0));
    else if (op == IN_) prog.push_back(mk(B_RDM, 1'b0, 1'b0, 2'b01, 3'b0));
    else                prog.push_back(rd);
    prog.push_back(final_write(op));
  endtask

  task automatic check_quiet(input string tag, input logic exp_halted);
    chk({tag, " step"}, 32'(step), 32'd1);
    chk({tag, " strobes"}, {20'd0, mem_req, obs_s()}, 32'd0);
    chk({tag, " halted"}, 32'(halted), 32'(exp_halted));
  endtask

  // Driver: call right after a falling edge with the DUT at T0.
  task automatic run_instr(input string name, input logic [15:0] ops, input logic [1:0] md,
                           input logic fn, input logic fz, input int stall_max,
                           input int fix_idx, input int fix_n, input int abort_at,
                           input int halt_cycles);
    bit halts, ready, stalled;
    int stalls;
    string tag;
    build(ops, md, fn, fz, halts);
    op_sel = ops;
    mode   = md;
    for (int idx = 0; idx < prog.size(); idx++) begin
      stalls = 0;
      tag = $sformatf("%s T%0d", name, idx);
      forever begin
        flag_n = (idx == 3) ? fn : 1'($urandom_range(0, 1));
        flag_z = (idx == 3) ? fz : 1'($urandom_range(0, 1));
        if (idx == fix_idx)                       ready = (stalls >= fix_n);
        else if (stall_max == 0)                  ready = 1'b1;
        else if (prog[idx].mem && stalls >= stall_max) ready = 1'b1;
        else                                      ready = 1'($urandom_range(0, 1));
        mem_ready = ready;
        stalled = prog[idx].mem && !ready;
        if (idx == abort_at) begin
          rst_n = 1'b0;
          #1 check_quiet({tag, " abort"}, 1'b0);
          @(negedge clk);
          return;
        end
        #1;
        chk({tag, " step"}, 32'(step), 32'(10'(1) << idx));
        chk({tag, " mem_req"}, 32'(mem_req), 32'(prog[idx].mem));
        chk({tag, " strobes"}, 32'(obs_s()), stalled ? 32'd0 : 32'(prog[idx].s));
        chk({tag, " halted"}, 32'(halted), 32'd0);
        if (!stalled && prog[idx].s[3]) chk({tag, " select_rem"}, 32'(select_rem), 32'(prog[idx].sel_rem));
        if (!stalled && prog[idx].s[6]) chk({tag, " select_rdm"}, 32'(select_rdm), 32'(prog[idx].sel_rdm));
        if (!stalled && prog[idx].s[10]) chk({tag, " op_ula"}, 32'(op_ula), 32'(prog[idx].ula));
        @(negedge clk);
        if (!stalled) break;
        stalls++;
      end
    end
    if (halts) begin
      for (int k = 0; k < halt_cycles; k++) begin
        mem_ready = 1'($urandom_range(0, 1));
        flag_n = 1'($urandom_range(0, 1));
        #1 check_quiet($sformatf("%s halted%0d", name, k), 1'b1);
        @(negedge clk);
      end
      resume = 1'b1;
      #1 check_quiet({name, " resume"}, 1'b1);
      @(negedge clk);
      resume = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; op_sel = '0; mode = '0; flag_n = 1'b0; flag_z = 1'b0;
    mem_ready = 1'b1; resume = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_quiet("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("dir_lda",    16'(1) << LDA,  M_DIR, 1'b0, 1'b0, 0, -1, 0, -1, 0);
    run_instr("dir_add_st", 16'(1) << ADD,  M_DIR, 1'b0, 1'b0, 0,  6, 3, -1, 0);
    run_instr("jz_dir_z0",  16'(1) << JZ,   M_DIR, 1'b1, 1'b0, 0, -1, 0, -1, 0);
    run_instr("jz_dir_z1",  16'(1) << JZ,   M_DIR, 1'b0, 1'b1, 0, -1, 0, -1, 0);
    run_instr("ind_j",      16'(1) << J,    M_IND, 1'b0, 1'b0, 0, -1, 0, -1, 0);
    run_instr("hlt",        16'(1) << HLT,  M_SOP, 1'b0, 1'b0, 0, -1, 0, -1, 20);
    run_instr("not_sop",    16'(1) << NOT_, M_SOP, 1'b0, 1'b0, 0, -1, 0, -1, 0);
    run_instr("im_sta",     16'(1) << STA,  M_IM,  1'b0, 1'b0, 0, -1, 0, -1, 0);
    run_instr("op_zero",    16'd0,          M_DIR, 1'b0, 1'b0, 0, -1, 0, -1, 0);
    run_instr("ind_sta",    16'(1) << STA,  M_IND, 1'b0, 1'b0, 2, -1, 0, -1, 0);
    run_instr("ind_sub_rst", 16'(1) << SUB, M_IND, 1'b0, 1'b0, 0, -1, 0,  8, 0);
    #1 check_quiet("rst_held", 1'b0);
    rst_n = 1'b1;
    run_instr("im_out",     16'(1) << OUT_, M_IM,  1'b0, 1'b0, 0, -1, 0, -1, 0);

    for (int n = 0; n < 60; n++) begin
      logic [15:0] ops;
      if ($urandom_range(0, 7) == 0) ops = 16'($urandom_range(0, 65535));
      else                           ops = 16'(1) << $urandom_range(0, 15);
      run_instr($sformatf("rnd%0d", n), ops, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3, -1, 0, -1, $urandom_range(1, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Parametrised successor to the accumulator CPU control unit. It generates the one-hot timing steps and the datapath control strobes for fetch, decode and execute. It adds:
- an asynchronous active-low reset;
- a memory ready/wait handshake;
- a real HLT state with resume;
- illegal-combination detection.

It sits between the instruction decoder (one-hot opcode, addressing mode) and the datapath (AC, PC, REM, RDM, RI, N/Z, OUT, ULA).

Parameters:
NUM_STEPS, 10, length of the one-hot step register; must be >= 10.
OP_W, 3, ULA operation code width.
MEM_WAIT, 1, 1 = memory steps stall on mem_ready; 0 = single-cycle memory, mem_ready ignored.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
op_sel  in  16  one-hot opcode; bit indices from package (NOP,STA,LDA,ADD,SUB,AND,OR,NOT,J,JN,JZ,IN,OUT,SHR,SHL,HLT)
mode  in  2  addressing mode: 00 SOP, 01 DIR, 10 IND, 11 IM
flag_n, flag_z  in  1 each  current N and Z flags
mem_ready  in  1  memory completes the current access this cycle
resume  in  1  leave the HALTED state
mem_req  out  1  memory access requested in the current step
write_ac, write_pc, write_n, write_z, write_rdm, write_ri, write_out, write_rem, write_mem  out  1 each  register/memory write strobes
select_rem  out  1  1 = REM<-PC, 0 = REM<-RDM
increment_pc  out  1  PC<=PC+1
select_rdm  out  2  00 AC, 01 IN, 10 MEM
op_ula  out  OP_W  ADD 000, SUB 001, AND 010, OR 011, NOT 100, SHR 101, SHL 110, LDA(pass) 111
step  out  NUM_STEPS  one-hot current step (T0 = bit 0)
halted  out  1  sequencer is in the HALTED state
illegal  out  1  one-cycle pulse at T3 on an illegal opcode/mode combination

Behaviour:
- State: one-hot step register plus a halted flag.
- Reset: rst_n low asynchronously sets step=T0 and halted=0. While reset is asserted, every strobe and mem_req is 0. Reset mid-instruction abandons the instruction.
- Outputs are combinational decodes of step, op_sel, mode and flags.

Fetch (all instructions):
- T0: write_rem, select_rem=1.
- T1: mem_req; write_rdm with select_rdm=10; increment_pc.
- T2: write_ri.
- T3: execute or begin operand phase.

Memory steps and the MEM_WAIT handshake:
- Memory steps are those with mem_req=1: RDM<-MEM reads and write_mem writes.
- When MEM_WAIT=1, every strobe of a memory step is gated by mem_ready, and step advances only in the cycle mem_ready=1.
- increment_pc and write_mem therefore assert exactly once per step, regardless of the stall length.

SOP (mode 00), at T3:
- NOT/SHR/SHL: write_ac, write_n, write_z with the matching op_ula, then go to T0.
- NOP: go to T0.
- HLT: set halted and go to T0.
- HALTED: step is held at T0 and all strobes are masked. resume=1 clears halted, and fetch proceeds from the next cycle. Reset also clears halted.

IM (mode 11), LDA/ADD/SUB/AND/OR/OUT:
- T3: write_rem, select_rem=1.
- T4: mem read; increment_pc.
- T5: write_ac/n/z (or write_out for OUT); then T0.

IM, illegal combinations:
- STA, IN, J, JN and JZ in IM, and any opcode outside SOP ops in mode 00 (or SOP ops outside mode 00), are illegal.
- At T3 they pulse illegal and assert increment_pc (operand skipped), then go to T0.
- If op_sel is not one-hot, illegal pulses at T3 and step goes to T0 with no increment.

DIR (mode 01):
- T3: REM<-PC.
- T4: mem read; increment_pc.
- T5: REM<-RDM (select_rem=0).
- T6: RDM<-MEM; for STA RDM<-AC; for IN RDM<-IN.
- T7: ALU ops/LDA write_ac/n/z; OUT write_out; STA/IN write_mem (memory step).
- Then T0.

IND (mode 10):
- T3..T6 as DIR, with T6 always a memory read.
- T7: REM<-RDM.
- T8: data access as DIR T6.
- T9: final write as DIR T7.
- Then T0.

Jumps:
- JN with N=0, or JZ with Z=0: at T3 assert increment_pc and go to T0.
- Taken jump, DIR: T3 REM<-PC; T4 RDM<-MEM; T5 write_pc; then T0.
- Taken jump, IND: T5 REM<-RDM; T6 RDM<-MEM; T7 write_pc; then T0.

Flags and ordering:
- Flags are sampled in T3 only; later changes do not alter the path.
- The step register never advances past T9. Any unused step returns to T0.

Decomposition:
- Package ctrl_pkg holds: opcode bit indices, mode encodings, select_rdm and op_ula localparams, and step index names T0..T9.
- One sub-module, step_counter: one-hot shift register with async reset, and advance/restart/hold inputs.
- The strobe decode stays in control_sequencer.

Test Plan:
1. Reset, then DIR LDA with mem_ready tied 1: step T0..T7. write_ac, op_ula=111 at T7. increment_pc exactly at T1 and T4. Back to T0.
2. DIR ADD with mem_ready low 3 cycles at T6: step held 3 cycles. write_rdm asserts once, in the mem_ready cycle. No duplicate increment_pc.
3. JZ DIR with Z=0: increment_pc at T3, then T0. With Z=1: write_pc at T5. IND J: write_pc at T7.
4. HLT: halted=1 and step stays T0 for 20 cycles with all strobes 0. Pulse resume: write_rem asserts the next cycle.
5. IM STA: illegal pulses at T3 with increment_pc, then T0. op_sel=0: illegal pulses, no increment.
6. Assert rst_n low during IND T8: step=T0 and all strobes 0 immediately. Release: fetch restarts cleanly.
